// File: rtl/ascon_aead_stream.sv
// Streaming Ascon v1.2 AEAD core: one permutation round per clock, AD and message
// blocks arrive on a valid/ready stream, ciphertext/plaintext leaves on another.
module ascon_aead_stream #(
  parameter int R  = 64,
  parameter int PA = 12,
  parameter int PB = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [127:0]         key,
  input  logic [127:0]         nonce,
  input  logic [R-1:0]         in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 in_type,
  input  logic [$clog2(R/8):0] in_bytes,
  output logic                 in_ready,
  output logic [R-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [127:0]         tag_in,
  output logic [127:0]         tag_out,
  output logic                 done,
  output logic                 auth_ok,
  output logic                 busy
);
  localparam int BW = $clog2(R/8) + 1;
  localparam logic [63:0]   IV    = {8'd128, 8'(R), 8'(PA), 8'(PB), 32'h0};
  localparam logic [3:0]    RND_A = 4'(12 - PA);
  localparam logic [3:0]    RND_B = 4'(12 - PB);
  localparam logic [BW-1:0] FULL  = BW'(R / 8);

  typedef enum logic [3:0] {IDLE, INIT, AD, AD_PERM, SEP, MSG, MSG_PERM, FINAL, DONE} state_t;
  state_t state, state_nx;

  logic [319:0] s, perm_out, fin_key;
  logic [3:0]   rnd;
  logic         mode_r, pad_pend, ad_fin, auth_r, beat, last_rnd;
  logic [127:0] key_r, tag_r, tag_nx;
  logic [R-1:0] sr, msk, pad, blk, sr_msg, msg_out;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] perm_round(input logic [319:0] st, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = st;
    x2 = x2 ^ {56'h0, 4'hf - r, r};
    x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
    x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Leading-byte keep mask and the 0x80 pad byte position for a partial block.
  function automatic logic [R-1:0] byte_mask(input logic [BW-1:0] n);
    return ~({R{1'b1}} >> (8 * n));
  endfunction

  function automatic logic [R-1:0] pad_at(input logic [BW-1:0] n);
    return {8'h80, {(R-8){1'b0}}} >> (8 * n);
  endfunction

  always_comb begin
    sr       = s[319 -: R];
    msk      = in_last ? byte_mask(in_bytes) : '1;
    pad      = in_last ? pad_at(in_bytes) : '0;
    blk      = (in_data & msk) ^ pad;
    perm_out = perm_round(s, rnd);
    last_rnd = (rnd == 4'd11);
    fin_key  = {key_r, 192'h0} >> R;
    tag_nx   = perm_out[127:0] ^ key_r;
    if (mode_r) begin
      sr_msg  = ((in_data & msk) | (sr & ~msk)) ^ pad;
      msg_out = (sr ^ in_data) & msk;
    end else begin
      sr_msg  = sr ^ blk;
      msg_out = sr_msg & msk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    if (state == AD)       in_ready = !pad_pend && !(in_valid && in_type);
    else if (state == MSG) in_ready = !out_valid;
    beat = in_valid && in_ready;
    case (state)
      IDLE, DONE: if (start) state_nx = INIT;
      INIT:       if (last_rnd) state_nx = AD;
      AD: begin
        // A message beat arriving in AD closes the AD phase without being consumed.
        if (pad_pend || beat)          state_nx = AD_PERM;
        else if (in_valid && in_type)  state_nx = SEP;
      end
      AD_PERM:    if (last_rnd) state_nx = ad_fin ? SEP : AD;
      SEP:        state_nx = MSG;
      MSG:        if (beat) state_nx = in_last ? FINAL : MSG_PERM;
      MSG_PERM:   if (last_rnd) state_nx = MSG;
      FINAL:      if (last_rnd) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= '0; rnd <= '0; mode_r <= 1'b0; key_r <= '0; tag_r <= '0; auth_r <= 1'b0;
      pad_pend <= 1'b0; ad_fin <= 1'b0; out_valid <= 1'b0; out_data <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          s <= {IV, key, nonce}; key_r <= key; mode_r <= mode;
          rnd <= RND_A; pad_pend <= 1'b0; ad_fin <= 1'b0;
        end
        INIT: begin
          s   <= last_rnd ? (perm_out ^ {192'h0, key_r}) : perm_out;
          rnd <= rnd + 4'd1;
        end
        AD: begin
          if (pad_pend) begin
            s[319 -: R] <= sr ^ pad_at('0);
            pad_pend <= 1'b0; ad_fin <= 1'b1; rnd <= RND_B;
          end else if (beat) begin
            s[319 -: R] <= sr ^ blk;
            rnd <= RND_B;
            if (in_last) begin
              if (in_bytes == FULL) pad_pend <= 1'b1;
              else                  ad_fin   <= 1'b1;
            end
          end
        end
        AD_PERM, MSG_PERM: begin
          s <= perm_out; rnd <= rnd + 4'd1;
        end
        SEP: s <= s ^ 320'd1;
        MSG: if (beat) begin
          out_data <= msg_out;
          if (!in_last || in_bytes != '0) out_valid <= 1'b1;
          if (in_last) begin
            s <= {sr_msg, s[319-R:0]} ^ fin_key; rnd <= RND_A;
          end else begin
            s[319 -: R] <= sr_msg; rnd <= RND_B;
          end
        end
        FINAL: begin
          s <= perm_out; rnd <= rnd + 4'd1;
          if (last_rnd) begin
            tag_r  <= tag_nx;
            auth_r <= mode_r && ~|(tag_nx ^ tag_in);
          end
        end
        default: ;
      endcase
    end
  end

  assign done    = (state == DONE);
  assign busy    = (state != IDLE) && (state != DONE);
  assign tag_out = done ? tag_r : '0;
  assign auth_ok = done && auth_r;
endmodule

// File: tb/tb_ascon_aead_stream.sv
// Directed bench for ascon_aead_stream (R=64): known-answer tag, encrypt/decrypt
// round trips against a table-driven software Ascon model, backpressure and reset.
`timescale 1ns/1ps
module tb_ascon_aead_stream;
  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [127:0] key = '0, nonce = '0, tag_in = '0;
  logic [63:0]  in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_type = 1'b0;
  logic [3:0]   in_bytes = '0;
  logic in_ready, out_valid, done, auth_ok, busy;
  logic out_ready = 1'b1;
  logic [63:0]  out_data;
  logic [127:0] tag_out;

  int checks = 0, failures = 0;
  wq_t outq;

  localparam logic [127:0] K   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT = 128'hE355159F292911F794CB1432A0103A8A;

  logic [4:0] sbox_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clk = ~clk;

  ascon_aead_stream dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .nonce(nonce),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_type(in_type),
    .in_bytes(in_bytes), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .tag_in(tag_in), .tag_out(tag_out), .done(done),
    .auth_ok(auth_ok), .busy(busy)
  );

  always @(posedge clk) if (rst && out_valid && out_ready) outq.push_back(out_data);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference permutation using the 5-bit S-box table column by column.
  function automatic logic [319:0] model_p(input logic [319:0] st, input int n);
    logic [63:0] x [5];
    logic [4:0]  v;
    for (int k = 0; k < 5; k++) x[k] = st[319 - 64*k -: 64];
    for (int r = 12 - n; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int j = 0; j < 64; j++) begin
        v = sbox_t[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
        x[0][j] = v[4]; x[1][j] = v[3]; x[2][j] = v[2]; x[3][j] = v[1]; x[4][j] = v[0];
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [63:0] pack(input bq_t q, input int off, input int n);
    logic [63:0] w = '0;
    for (int i = 0; i < n; i++) w[63 - 8*i -: 8] = q[off + i];
    return w;
  endfunction

  function automatic bq_t unpack(input wq_t w, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(w[i/8][63 - 8*(i%8) -: 8]);
    return q;
  endfunction

  task automatic model_enc(input logic [127:0] k, input logic [127:0] nn, input bq_t ad,
                           input bq_t msg, output wq_t ct, output logic [127:0] tag);
    logic [319:0] s;
    logic [63:0]  b;
    bq_t a;
    int rem, full;
    s = {64'h80400C0600000000, k, nn};
    s = model_p(s, 12);
    s[127:0] = s[127:0] ^ k;
    if (ad.size() > 0) begin
      a = ad;
      a.push_back(8'h80);
      while (a.size() % 8 != 0) a.push_back(8'h00);
      for (int i = 0; i < a.size(); i += 8) begin
        s[319:256] = s[319:256] ^ pack(a, i, 8);
        s = model_p(s, 6);
      end
    end
    s[0] = ~s[0];
    ct = {};
    rem  = msg.size() % 8;
    full = msg.size() - rem;
    for (int i = 0; i < full; i += 8) begin
      s[319:256] = s[319:256] ^ pack(msg, i, 8);
      ct.push_back(s[319:256]);
      s = model_p(s, 6);
    end
    b = pack(msg, full, rem);
    b[63 - 8*rem -: 8] = b[63 - 8*rem -: 8] ^ 8'h80;
    s[319:256] = s[319:256] ^ b;
    if (rem > 0) ct.push_back(s[319:256] & ~(64'hFFFFFFFFFFFFFFFF >> (8*rem)));
    s[255:128] = s[255:128] ^ k;
    s = model_p(s, 12);
    tag = s[127:0] ^ k;
  endtask

  task automatic do_start(input logic m, input logic [127:0] k, input logic [127:0] nn,
                          input logic [127:0] ti);
    @(negedge clk);
    mode = m; key = k; nonce = nn; tag_in = ti; start = 1'b1;
    outq.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic typ, input logic [63:0] d, input logic last,
                           input logic [3:0] nb);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_type = typ; in_data = d; in_last = last; in_bytes = nb;
    forever begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        break;
      end
      n++;
      if (n > 300) begin
        check("beat_timeout", 128'(in_ready), 128'd1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_ad(input bq_t ad);
    int n;
    for (int i = 0; i < ad.size(); i += 8) begin
      n = (ad.size() - i >= 8) ? 8 : ad.size() - i;
      send_beat(1'b0, pack(ad, i, n), (i + 8 >= ad.size()), 4'(n));
    end
  endtask

  // Returns right after the clock edge that transfers the last message beat.
  task automatic send_msg(input bq_t m);
    int rem, full;
    rem  = m.size() % 8;
    full = m.size() - rem;
    for (int i = 0; i < full; i += 8) send_beat(1'b1, pack(m, i, 8), 1'b0, 4'd0);
    send_beat(1'b1, pack(m, full, rem), 1'b1, 4'(rem));
  endtask

  task automatic finish_op(output logic [127:0] tg, output logic au, output logic dn,
                           output logic bz);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    while (!(done && !out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("done_timeout", 128'(done), 128'd1);
    tg = tag_out; au = auth_ok; dn = done; bz = busy;
  endtask

  task automatic run_op(input logic m, input logic [127:0] ti, input bq_t ad, input bq_t msg,
                        output wq_t outs, output logic [127:0] tg, output logic au);
    logic dn, bz;
    do_start(m, K, K, ti);
    if (ad.size() > 0) send_ad(ad);
    send_msg(msg);
    finish_op(tg, au, dn, bz);
    outs = outq;
  endtask

  task automatic cmp_beats(input string nm, input wq_t got, input wq_t exp);
    check({nm, "_cnt"}, 128'(got.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s_%0d", nm, i), 128'(got[i]), 128'(exp[i]));
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_ctl"}, 128'({in_ready, out_valid, done, auth_ok, busy}), 128'd0);
    check({nm, "_data"}, 128'(out_data), 128'd0);
    check({nm, "_tag"}, tag_out, 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t empty, ad3, pt13, ad8, pt16, ct13;
    wq_t outs, exp_ct, pt_beats;
    logic [127:0] tg, exp_tag;
    logic au, dn, bz;
    logic [63:0] d0;

    for (int i = 0; i < 3;  i++) ad3.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 13; i++) pt13.push_back(8'(i));
    for (int i = 0; i < 8;  i++) ad8.push_back(8'(8'h30 + i));
    for (int i = 0; i < 16; i++) pt16.push_back(8'(8'hF0 - i));

    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;

    // Empty AD, empty message: known-answer tag.
    do_start(1'b0, K, K, '0);
    send_msg(empty);
    finish_op(tg, au, dn, bz);
    check("kat_enc_tag", tg, KAT);
    check("kat_enc_done", 128'(dn), 128'd1);
    check("kat_enc_auth", 128'(au), 128'd0);
    check("kat_enc_busy", 128'(bz), 128'd0);
    check("kat_enc_beats", 128'(outq.size()), 128'd0);

    run_op(1'b1, KAT, empty, empty, outs, tg, au);
    check("kat_dec_tag", tg, KAT);
    check("kat_dec_auth", 128'(au), 128'd1);
    run_op(1'b1, KAT ^ 128'd1, empty, empty, outs, tg, au);
    check("kat_badtag_auth", 128'(au), 128'd0);

    // 3-byte AD, 13-byte message, then decrypt the model ciphertext.
    model_enc(K, K, ad3, pt13, exp_ct, exp_tag);
    run_op(1'b0, '0, ad3, pt13, outs, tg, au);
    cmp_beats("enc13", outs, exp_ct);
    check("enc13_tag", tg, exp_tag);
    ct13 = unpack(exp_ct, 13);
    pt_beats = {pack(pt13, 0, 8), pack(pt13, 8, 5)};
    run_op(1'b1, exp_tag, ad3, ct13, outs, tg, au);
    cmp_beats("dec13", outs, pt_beats);
    check("dec13_tag", tg, exp_tag);
    check("dec13_auth", 128'(au), 128'd1);

    // Full 8-byte AD forces the internal pad block; 16-byte message ends with an empty block.
    model_enc(K, K, ad8, pt16, exp_ct, exp_tag);
    run_op(1'b0, '0, ad8, pt16, outs, tg, au);
    cmp_beats("enc16", outs, exp_ct);
    check("enc16_tag", tg, exp_tag);

    // Output backpressure for 10 cycles while the message streams.
    fork
      run_op(1'b0, '0, ad8, pt16, outs, tg, au);
      begin
        int n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        if (n >= 300) check("stall_wait", 128'(out_valid), 128'd1);
        d0 = out_data;
        repeat (10) begin
          @(negedge clk);
          check("stall_valid", 128'(out_valid), 128'd1);
          check("stall_data", 128'(out_data), 128'(d0));
          check("stall_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
      end
    join
    cmp_beats("stall16", outs, exp_ct);
    check("stall16_tag", tg, exp_tag);

    // Reset asserted during the fifth FINAL cycle, then a fresh operation.
    do_start(1'b0, K, K, '0);
    send_msg(empty);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("final_rst");
    @(negedge clk);
    rst = 1'b1;
    do_start(1'b0, K, K, '0);
    send_msg(empty);
    finish_op(tg, au, dn, bz);
    check("post_rst_tag", tg, KAT);
    check("post_rst_done", 128'(dn), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascon_aead_stream.md
ASCON_AEAD_STREAM -- requirements
Module: ascon_aead_stream

Interface
REQ-001 SHALL have parameter R, default 64, meaning the rate in bits; legal values are 64 and 128.
REQ-002 SHALL have parameter PA, default 12, meaning the round count for initialization and finalization.
REQ-003 SHALL have parameter PB, default 6, meaning the round count for data blocks when R=64 (use 8 when R=128).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin an operation; sampled only in IDLE or DONE.
REQ-007 SHALL have port mode, input, 1 bit: 0 encrypt, 1 decrypt; latched on start.
REQ-008 SHALL have ports key and nonce, inputs, 128 bits each; latched on start.
REQ-009 SHALL have port in_data, input, R bits: AD/message block, MSB-first byte order.
REQ-010 SHALL have ports in_valid, in_last and in_type, inputs, 1 bit each; in_type is 0 for AD, 1 for message.
REQ-011 SHALL have port in_bytes, input, clog2(R/8)+1 bits: valid leading bytes of a last block (0..R/8).
REQ-012 SHALL have port in_ready, output, 1 bit: an input beat transfers when in_valid and in_ready are both high.
REQ-013 SHALL have ports out_data (output, R bits), out_valid (output, 1 bit) and out_ready (input, 1 bit): the ciphertext/plaintext stream.
REQ-014 SHALL have port tag_in, input, 128 bits: the expected tag in decrypt mode; sampled in FINAL.
REQ-015 SHALL have ports tag_out (output, 128 bits), done (output, 1 bit), auth_ok (output, 1 bit) and busy (output, 1 bit).

Function
REQ-016 SHALL implement Ascon v1.2 AEAD with IV = {8'd128, R[7:0], PA[7:0], PB[7:0], 32'h0} (0x80400C0600000000 for R=64).
REQ-017 SHALL use FSM states IDLE, INIT, AD, AD_PERM, SEP, MSG, MSG_PERM, FINAL, DONE.
REQ-018 SHALL move IDLE->INIT on start; load S={IV,key,nonce}; run p^PA; then XOR key into the low 128 bits of S.
REQ-019 SHALL, in AD, XOR each accepted in_type=0 block into Sr, then go to AD_PERM (p^PB) and return to AD.
REQ-020 SHALL, on an AD beat with in_last, pad at byte in_bytes (0x80 followed by zeros); if in_bytes=R/8, append one internally generated pad block 0x80..0 with its own p^PB.
REQ-021 SHALL skip all AD processing, including pad and permutation, when the first beat after INIT has in_type=1.
REQ-022 SHALL, in SEP, XOR 1 into S[0] in one cycle, then enter MSG.
REQ-023 SHALL, for encrypt in MSG: Sr ^= P; out_data = new Sr.
REQ-024 SHALL, for decrypt in MSG: out_data = Sr ^ C; Sr = C on valid bytes; the pad byte XORs into Sr at byte in_bytes.
REQ-025 SHALL force out_data bytes beyond in_bytes to zero on a last block.
REQ-026 SHALL treat a last message block with in_bytes=0 as an empty block: out_valid is not raised, only padding applies.
REQ-027 SHALL, for non-last message blocks, run MSG_PERM (p^PB) after the beat; the last block goes directly to FINAL with no p^PB.
REQ-028 SHALL, in FINAL: S ^= {R'b0, key, zeros}; run p^PA; tag_out = S[127:0] ^ key; then enter DONE.
REQ-029 SHALL hold in_ready low except in AD/MSG with no pending output (out_valid=0).
REQ-030 SHALL hold out_valid and out_data stable until out_ready; out_valid rises the cycle after the input beat.
REQ-031 SHALL set auth_ok in DONE to (tag_out == tag_in) when mode=1, and to 0 when mode=0; the comparison evaluates all 128 bits with no early exit.
REQ-032 SHALL assert done only in DONE, hold tag_out/auth_ok there, and drive them to zero elsewhere.
REQ-033 SHALL assert busy in every state except IDLE and DONE.
REQ-034 SHALL ignore start while busy; start in DONE begins a new operation directly (DONE->INIT).
REQ-035 SHALL execute permutation rounds at one round per cycle, so p^n takes exactly n cycles.

Reset
REQ-036 SHALL, on rst=0 at a clock edge, go to IDLE; clear S, counters and tag; force in_ready, out_valid, done, auth_ok, busy, out_data and tag_out to 0.
REQ-037 SHALL honour reset mid-permutation or mid-handshake with no residual state; the first start after release behaves as after power-up.

Verification
REQ-038 SHALL pass: R=64, key=nonce=000102..0F, empty AD, empty message, encrypt -> tag_out=E355159F292911F794CB1432A0103A8A, done=1, auth_ok=0.
REQ-039 SHALL pass: same stimulus, decrypt, tag_in=E355159F292911F794CB1432A0103A8A -> auth_ok=1; with one bit flipped in tag_in -> auth_ok=0.
REQ-040 SHALL pass: R=64, 3-byte AD, 13-byte message, encrypt then decrypt of the ciphertext -> original plaintext, identical tag, auth_ok=1, tail bytes zero.
REQ-041 SHALL pass: exact 8-byte AD and 16-byte message -> extra AD pad block executes, no extra out beat; result equals the software model.
REQ-042 SHALL pass: out_ready held low for 10 cycles during MSG -> out_data stable, in_ready=0, no data lost.
REQ-043 SHALL pass: rst=0 during FINAL cycle 5 -> all outputs 0 next cycle; the following operation matches the golden model.
